// File: rtl/osnt_bram_replay_ctrl.sv
// Block-RAM packet store sequencer: loads AXI4-Stream beats into a single-port BRAM
// (one beat per word) and replays the stored packets a programmable number of times.
module osnt_bram_replay_ctrl #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 736,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                     axis_aclk,
  input  logic                     axis_resetn,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     load_start,
  input  logic                     load_stop,
  input  logic                     replay_start,
  input  logic                     replay_stop,
  input  logic [31:0]              replay_count,
  output logic [ADDR_WIDTH:0]      mem_words,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  output logic [DATA_WIDTH-1:0]    bram_wrdata,
  input  logic [DATA_WIDTH-1:0]    bram_rddata,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [1:0]               dbg_state_o
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int PW = TDATA_WIDTH + TUSER_WIDTH + KW + 1;
  localparam logic [ADDR_WIDTH:0] ONE_W = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DROP, S_REPLAY} state_t;

  // Both streams use AXI4-Stream valid/ready: a beat transfers on a rising edge where
  // tvalid && tready; a source holding tvalid keeps its payload stable until then.

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   pkt_base_q, pkt_base_d;
  logic [ADDR_WIDTH:0]   mem_words_q, mem_words_d;
  logic                  ovf_q, ovf_d;
  logic                  lstop_q, lstop_d;
  logic                  rstop_q, rstop_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]           passes_q, passes_d;
  logic                  infinite_q, infinite_d;
  logic                  issue_done_q, issue_done_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [PW-1:0]         buf0_q, buf0_d;
  logic [PW-1:0]         buf1_q, buf1_d;
  logic                  done_q, done_d;

  logic                  pop, push, issue, end_rep;
  logic [2:0]            occ;
  logic [PW-1:0]         rd_word;

  assign rd_word = bram_rddata[PW-1:0];

  generate
    if (DATA_WIDTH > PW) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^bram_rddata[DATA_WIDTH-1:PW];
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pkt_base_d    = pkt_base_q;
    mem_words_d   = mem_words_q;
    ovf_d         = ovf_q;
    lstop_d       = lstop_q;
    rstop_d       = rstop_q;
    rd_ptr_d      = rd_ptr_q;
    passes_d      = passes_q;
    infinite_d    = infinite_q;
    issue_done_d  = issue_done_q;
    inflight_d    = inflight_q;
    cnt_d         = cnt_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    done_d        = 1'b0;
    s_axis_tready = 1'b0;
    bram_en       = 1'b0;
    bram_we       = 1'b0;
    bram_addr     = '0;
    bram_wrdata   = '0;
    pop           = 1'b0;
    push          = 1'b0;
    issue         = 1'b0;
    end_rep       = 1'b0;
    occ           = '0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d     = S_LOAD;
          wr_ptr_d    = '0;
          pkt_base_d  = '0;
          mem_words_d = '0;
          ovf_d       = 1'b0;
          lstop_d     = 1'b0;
        end else if (replay_start) begin
          if (mem_words_q != '0) begin
            state_d      = S_REPLAY;
            rd_ptr_d     = '0;
            passes_d     = replay_count;
            infinite_d   = (replay_count == 32'd0);
            issue_done_d = 1'b0;
            rstop_d      = 1'b0;
            cnt_d        = '0;
            inflight_d   = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        lstop_d = lstop_q | load_stop;
        if (lstop_q && (wr_ptr_q == pkt_base_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            if (wr_ptr_q[ADDR_WIDTH]) begin
              // Store is full mid-packet: forget the partial packet and skip its rest.
              ovf_d    = 1'b1;
              wr_ptr_d = pkt_base_q;
              if (!s_axis_tlast) begin
                state_d = S_DROP;
              end else if (lstop_d) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              bram_en               = 1'b1;
              bram_we               = 1'b1;
              bram_addr             = wr_ptr_q[ADDR_WIDTH-1:0];
              bram_wrdata[PW-1:0]   = {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata};
              wr_ptr_d              = wr_ptr_q + ONE_W;
              if (s_axis_tlast) begin
                pkt_base_d  = wr_ptr_q + ONE_W;
                mem_words_d = wr_ptr_q + ONE_W;
                if (lstop_d) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end
      end

      S_DROP: begin
        s_axis_tready = 1'b1;
        lstop_d       = lstop_q | load_stop;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = lstop_d ? S_IDLE : S_LOAD;
          done_d  = lstop_d;
        end
      end

      S_REPLAY: begin
        rstop_d = rstop_q | replay_stop;
        pop     = (cnt_q != 2'd0) && m_axis_tready;
        push    = inflight_q;
        if (pop && ((issue_done_q && (cnt_q == 2'd1) && !inflight_q) ||
                    (buf0_q[PW-1] && rstop_d))) begin
          end_rep = 1'b1;
        end
        if (end_rep) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          cnt_d      = '0;
          inflight_d = 1'b0;
        end else begin
          // Reads are throttled so buffered beats plus the read in flight never exceed two.
          occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
          issue = !issue_done_q && (occ < 3'd2);
          if (issue) begin
            bram_en   = 1'b1;
            bram_addr = rd_ptr_q;
            if ({1'b0, rd_ptr_q} == (mem_words_q - ONE_W)) begin
              rd_ptr_d = '0;
              if (!infinite_q) begin
                passes_d = passes_q - 32'd1;
                if (passes_q == 32'd1) issue_done_d = 1'b1;
              end
            end else begin
              rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
          end
          inflight_d = issue;
          case ({pop, push})
            2'b10: begin
              buf0_d = buf1_q;
              cnt_d  = cnt_q - 2'd1;
            end
            2'b01: begin
              if (cnt_q == 2'd0) buf0_d = rd_word;
              else               buf1_d = rd_word;
              cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
              if (cnt_q == 2'd1) begin
                buf0_d = rd_word;
              end else begin
                buf0_d = buf1_q;
                buf1_d = rd_word;
              end
            end
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      pkt_base_q   <= '0;
      mem_words_q  <= '0;
      ovf_q        <= 1'b0;
      lstop_q      <= 1'b0;
      rstop_q      <= 1'b0;
      rd_ptr_q     <= '0;
      passes_q     <= '0;
      infinite_q   <= 1'b0;
      issue_done_q <= 1'b0;
      inflight_q   <= 1'b0;
      cnt_q        <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pkt_base_q   <= pkt_base_d;
      mem_words_q  <= mem_words_d;
      ovf_q        <= ovf_d;
      lstop_q      <= lstop_d;
      rstop_q      <= rstop_d;
      rd_ptr_q     <= rd_ptr_d;
      passes_q     <= passes_d;
      infinite_q   <= infinite_d;
      issue_done_q <= issue_done_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      done_q       <= done_d;
    end
  end

  assign m_axis_tvalid = (state_q == S_REPLAY) && (cnt_q != 2'd0);
  assign m_axis_tdata  = buf0_q[TDATA_WIDTH-1:0];
  assign m_axis_tuser  = buf0_q[TDATA_WIDTH +: TUSER_WIDTH];
  assign m_axis_tkeep  = buf0_q[TDATA_WIDTH+TUSER_WIDTH +: KW];
  assign m_axis_tlast  = buf0_q[PW-1];
  assign mem_words     = mem_words_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_osnt_bram_replay_ctrl.sv
// Bench for osnt_bram_replay_ctrl: a 16-word store driven from a scenario table, with a
// queue-based model of what gets stored and replayed, plus hand-written corner sequences.
module tb_osnt_bram_replay_ctrl;

  localparam int AW  = 4;
  localparam int TDW = 32;
  localparam int TUW = 8;
  localparam int KW  = TDW / 8;
  localparam int PW  = TDW + TUW + KW + 1;
  localparam int DW  = 48;
  localparam int CAP = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [TDW-1:0] s_axis_tdata = '0;
  logic [KW-1:0]  s_axis_tkeep = '0;
  logic [TUW-1:0] s_axis_tuser = '0;
  logic           s_axis_tlast = 1'b0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic [TDW-1:0] m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic [TUW-1:0] m_axis_tuser;
  logic           m_axis_tlast, m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           load_start = 1'b0, load_stop = 1'b0;
  logic           replay_start = 1'b0, replay_stop = 1'b0;
  logic [31:0]    replay_count = '0;
  logic [AW:0]    mem_words;
  logic           busy, done, overflow;
  logic [AW-1:0]  bram_addr;
  logic [DW-1:0]  bram_wrdata;
  logic [DW-1:0]  bram_rddata = '0;
  logic           bram_en, bram_we;
  logic [1:0]     dbg_state;

  osnt_bram_replay_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)
  ) dut (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .load_start(load_start), .load_stop(load_stop),
    .replay_start(replay_start), .replay_stop(replay_stop), .replay_count(replay_count),
    .mem_words(mem_words), .busy(busy), .done(done), .overflow(overflow),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata),
    .bram_en(bram_en), .bram_we(bram_we), .dbg_state_o(dbg_state)
  );

  // Single-port BRAM with one-cycle registered read.
  logic [DW-1:0] mem [0:CAP-1];
  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_wrdata;
    if (bram_en && !bram_we) bram_rddata <= mem[bram_addr];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_viol = 0;
  bit bp_mode = 1'b0;
  logic [PW-1:0] model_q[$];
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  logic          stalled_prev = 1'b0;
  logic [PW-1:0] prev_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: drives replay backpressure, collects accepted beats, counts done pulses.
  always @(negedge clk) begin
    logic [PW-1:0] cur;
    m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    cur = {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata};
    if (stalled_prev && (!m_axis_tvalid || cur !== prev_word)) stall_viol++;
    if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur);
    stalled_prev = m_axis_tvalid && !m_axis_tready;
    prev_word    = cur;
    if (done) done_cnt++;
  end

  // ---------------- scenario table ----------------
  typedef struct packed {
    logic [2:0]      n_pkts;
    logic [3:0][4:0] len;
    logic [7:0]      count;
    logic            bp;
    logic            stop_in_pkt;
    logic [4:0]      exp_mem;
    logic            exp_ovf;
    logic [7:0]      exp_beats;
  } scen_t;

  function automatic scen_t mk(input int n, input int l0, input int l1, input int l2,
                               input int l3, input int cnt, input bit bp, input bit sip,
                               input int em, input bit eo, input int eb);
    scen_t r;
    r.n_pkts = 3'(n);
    r.len[0] = 5'(l0); r.len[1] = 5'(l1); r.len[2] = 5'(l2); r.len[3] = 5'(l3);
    r.count = 8'(cnt); r.bp = bp; r.stop_in_pkt = sip;
    r.exp_mem = 5'(em); r.exp_ovf = eo; r.exp_beats = 8'(eb);
    return r;
  endfunction

  scen_t tbl[8];

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < budget), 64'd1);
  endtask

  task automatic do_load(input scen_t s);
    int total = 0;
    int d0, len, tr_viol;
    bit fits;
    logic [PW-1:0] w;
    tr_viol = 0;
    model_q.delete();
    @(negedge clk);
    check("load_tready_pre", 64'(s_axis_tready), 64'd0);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("load_tready_rise", 64'(s_axis_tready), 64'd1);
    d0 = done_cnt;
    for (int p = 0; p < int'(s.n_pkts); p++) begin
      len  = int'(s.len[p]);
      fits = (total + len) <= CAP;
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          @(negedge clk);
        end
        s_axis_tdata  = $urandom;
        s_axis_tkeep  = 4'($urandom_range(1, 15));
        s_axis_tuser  = 8'($urandom);
        s_axis_tlast  = (b == len - 1);
        s_axis_tvalid = 1'b1;
        w = {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata};
        if (fits) model_q.push_back(w);
        if (s.stop_in_pkt && p == int'(s.n_pkts) - 1 && b == 0) load_stop = 1'b1;
        if (!s_axis_tready) tr_viol++;
        @(negedge clk);
        load_stop = 1'b0;
      end
      if (fits) total += len;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!s.stop_in_pkt) begin
      load_stop = 1'b1;
      @(negedge clk);
      load_stop = 1'b0;
    end
    wait_done(d0, 50, "load_done_timeout");
    @(negedge clk);
    check("load_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("load_mem_words", 64'(mem_words), 64'(s.exp_mem));
    check("load_model_words", 64'(mem_words), 64'(model_q.size()));
    check("load_overflow", 64'(overflow), 64'(s.exp_ovf));
    check("load_busy_low", 64'(busy), 64'd0);
    check("load_tready_held", 64'(tr_viol), 64'd0);
    if (model_q.size() > 0) begin
      check("pack_first", 64'(mem[0]), 64'({3'b000, model_q[0]}));
      check("pack_last", 64'(mem[model_q.size() - 1]), 64'({3'b000, model_q[model_q.size() - 1]}));
    end
  endtask

  task automatic do_replay(input int cnt, input bit bp, input int stop_at, input int exp_beats);
    int d0;
    int n = 0;
    bit stopped = 1'b0;
    exp_q.delete();
    for (int i = 0; i < exp_beats; i++) exp_q.push_back(model_q[i % model_q.size()]);
    bp_mode = bp;
    @(negedge clk);
    got_q.delete();
    stall_viol = 0;
    d0 = done_cnt;
    replay_count = 32'(cnt);
    replay_start = 1'b1;
    @(negedge clk);
    replay_start = 1'b0;
    check("replay_busy", 64'(busy), 64'd1);
    check("replay_lat_1", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    check("replay_lat_2", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    check("replay_lat_3", 64'(m_axis_tvalid), 64'd1);
    while (done_cnt == d0 && n < 1000) begin
      @(negedge clk);
      #1;
      replay_stop = 1'b0;
      if (stop_at >= 0 && !stopped && got_q.size() == stop_at) begin
        replay_stop = 1'b1;
        stopped = 1'b1;
      end
      n++;
    end
    replay_stop = 1'b0;
    check("replay_done_timeout", 64'(n < 1000), 64'd1);
    @(negedge clk);
    check("replay_beats", 64'(got_q.size()), 64'(exp_beats));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("replay_beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    check("replay_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("replay_stall_stable", 64'(stall_viol), 64'd0);
    check("replay_busy_low", 64'(busy), 64'd0);
    check("replay_tvalid_low", 64'(m_axis_tvalid), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, vcount;
    tbl[0] = mk(3, 4, 1, 7, 0, 2, 1'b0, 1'b0, 12, 1'b0, 24);
    tbl[1] = mk(3, 4, 1, 7, 0, 2, 1'b1, 1'b1, 12, 1'b0, 24);
    tbl[2] = mk(2, 10, 10, 0, 0, 1, 1'b0, 1'b0, 10, 1'b1, 10);
    tbl[3] = mk(2, 5, 11, 0, 0, 3, 1'b1, 1'b0, 16, 1'b0, 48);
    tbl[4] = mk(2, 8, 9, 0, 0, 2, 1'b1, 1'b1, 8, 1'b1, 16);
    tbl[5] = mk(3, 6, 6, 6, 0, 1, 1'b0, 1'b1, 12, 1'b1, 12);
    tbl[6] = mk(1, 1, 0, 0, 0, 3, 1'b1, 1'b0, 1, 1'b0, 3);
    tbl[7] = mk(4, 2, 3, 4, 2, 2, 1'b1, 1'b0, 11, 1'b0, 22);

    repeat (3) @(negedge clk);
    check("rst_mem_words", 64'(mem_words), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_bram_en", 64'(bram_en), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Replay with an empty store only pulses done.
    replay_count = 32'd1;
    replay_start = 1'b1;
    @(negedge clk);
    replay_start = 1'b0;
    check("empty_done", 64'(done), 64'd1);
    check("empty_busy", 64'(busy), 64'd0);
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_axis_tvalid) vcount++;
    end
    check("empty_no_tvalid", 64'(vcount), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i]);
      do_replay(int'(tbl[i].count), tbl[i].bp, -1, int'(tbl[i].exp_beats));
    end

    // Unlimited replay stopped during the 2nd beat of the 7-beat packet.
    do_load(tbl[0]);
    do_replay(0, 1'b0, 6, 12);

    // Load and replay requested together: load wins.
    @(negedge clk);
    load_start = 1'b1;
    replay_start = 1'b1;
    replay_count = 32'd1;
    @(negedge clk);
    load_start = 1'b0;
    replay_start = 1'b0;
    check("conflict_tready", 64'(s_axis_tready), 64'd1);
    check("conflict_busy", 64'(busy), 64'd1);
    check("conflict_mem_words", 64'(mem_words), 64'd0);
    check("conflict_tvalid", 64'(m_axis_tvalid), 64'd0);
    d0 = done_cnt;
    load_stop = 1'b1;
    @(negedge clk);
    load_stop = 1'b0;
    wait_done(d0, 20, "conflict_done_timeout");

    // Asynchronous reset in the middle of an unlimited replay.
    do_load(tbl[5]);
    bp_mode = 1'b0;
    @(negedge clk);
    replay_count = 32'd0;
    replay_start = 1'b1;
    @(negedge clk);
    replay_start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_streaming", 64'(m_axis_tvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    check("midrst_bram_en", 64'(bram_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_mem_words", 64'(mem_words), 64'd0);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_tvalid", 64'(m_axis_tvalid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
